// File: rtl/wb_dnsz_pkg.sv
// Shared types and helpers for the wb_dnsz Wishbone width down-converter.
package wb_dnsz_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    RESP  = 2'd3
  } dnsz_state_e;

  // Number of bits needed to name one narrow lane inside a wide word.
  function automatic int lane_idx_width(input int ratio);
    return $clog2(ratio);
  endfunction

endpackage

// File: rtl/wb_dnsz.sv
// wb_dnsz: pipelined Wishbone B4 width down-converter (wide slave -> narrow master).
// One wide request is split into narrow beats issued lowest lane first; read
// data is reassembled into the wide word in response order.
// Optional build macro WB_DNSZ_SKIP_EMPTY_LANES_EN: lanes whose byte selects
// are all zero are not issued on the narrow bus.
module wb_dnsz
  import wb_dnsz_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int WIDE_DW       = 128,
  parameter int SMALL_DW      = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       s_cyc_i,
  input  logic                       s_stb_i,
  input  logic                       s_we_i,
  input  logic [ADDRESS_WIDTH-1:0]   s_addr_i,
  input  logic [WIDE_DW-1:0]         s_wdata_i,
  input  logic [WIDE_DW/8-1:0]       s_sel_i,
  output logic                       s_stall_o,
  output logic                       s_ack_o,
  output logic [WIDE_DW-1:0]         s_rdata_o,
  output logic                       s_err_o,
  output logic                       m_cyc_o,
  output logic                       m_stb_o,
  output logic                       m_we_o,
  output logic [ADDRESS_WIDTH-1:0]   m_addr_o,
  output logic [SMALL_DW-1:0]        m_wdata_o,
  output logic [SMALL_DW/8-1:0]      m_sel_o,
  input  logic                       m_stall_i,
  input  logic                       m_ack_i,
  input  logic                       m_err_i,
  input  logic [SMALL_DW-1:0]        m_rdata_i
);

  localparam int RATIO = WIDE_DW / SMALL_DW;
  localparam int LW    = lane_idx_width(RATIO);
  localparam int CW    = LW + 1;
  localparam int SB    = SMALL_DW / 8;

  localparam logic [CW-1:0]    CNT_ONE   = {{LW{1'b0}}, 1'b1};
  localparam logic [CW-1:0]    CNT_ZERO  = {CW{1'b0}};
  localparam logic [RATIO-1:0] LANE_NONE = {RATIO{1'b0}};
  localparam logic [RATIO-1:0] LANE_ONE  = {{(RATIO-1){1'b0}}, 1'b1};

  // Index of the lowest set bit of a lane mask (0 when the mask is empty).
  function automatic logic [LW-1:0] lowest_lane(input logic [RATIO-1:0] mask);
    logic [LW-1:0] idx;
    idx = {LW{1'b0}};
    for (int i = RATIO - 1; i >= 0; i--) begin
      idx = mask[i] ? LW'(i) : idx;
    end
    return idx;
  endfunction

  // Which lanes of a wide request produce narrow beats.
  function automatic logic [RATIO-1:0] lane_enables(input logic [WIDE_DW/8-1:0] sel);
    logic [RATIO-1:0] en;
    en = LANE_NONE;
    for (int k = 0; k < RATIO; k++) begin
`ifdef WB_DNSZ_SKIP_EMPTY_LANES_EN
      en[k] = |sel[k*SB +: SB];
`else
      en[k] = 1'b1 | (&sel[k*SB +: SB]);
`endif
    end
    return en;
  endfunction

  dnsz_state_e                state_q, state_d;
  logic                       we_q, we_d;
  logic [ADDRESS_WIDTH-1:0]   addr_q, addr_d;
  logic [WIDE_DW-1:0]         wdata_q, wdata_d;
  logic [WIDE_DW/8-1:0]       sel_q, sel_d;
  logic [RATIO-1:0]           en_q, en_d;
  logic [RATIO-1:0]           iss_q, iss_d;
  logic [RATIO-1:0]           ackm_q, ackm_d;
  logic [CW-1:0]              iss_cnt_q, iss_cnt_d;
  logic [CW-1:0]              ack_cnt_q, ack_cnt_d;
  logic                       err_q, err_d;
  logic [WIDE_DW-1:0]         rdata_q, rdata_d;

  logic [RATIO-1:0]           pend_s;
  logic [LW-1:0]              cur_lane_s;
  logic [RATIO-1:0]           cur_bit_s;
  logic                       stb_s;
  logic                       accept_s;
  logic                       last_accept_s;
  logic [RATIO-1:0]           outst_s;
  logic [LW-1:0]              ack_lane_s;
  logic                       ack_ok_s;

  // Beat selection, response bookkeeping and next-state logic.
  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    sel_d     = sel_q;
    en_d      = en_q;
    iss_d     = iss_q;
    ackm_d    = ackm_q;
    iss_cnt_d = iss_cnt_q;
    ack_cnt_d = ack_cnt_q;
    err_d     = err_q;
    rdata_d   = rdata_q;

    pend_s        = en_q & ~iss_q;
    cur_lane_s    = lowest_lane(pend_s);
    cur_bit_s     = LANE_ONE << cur_lane_s;
    stb_s         = (state_q == ISSUE) && (pend_s != LANE_NONE);
    accept_s      = stb_s && !m_stall_i;
    last_accept_s = accept_s && ((pend_s & ~cur_bit_s) == LANE_NONE);
    // A beat accepted this cycle may already be acknowledged by a
    // combinational slave, so it counts as outstanding right away.
    outst_s       = (iss_q | (accept_s ? cur_bit_s : LANE_NONE)) & ~ackm_q;
    ack_lane_s    = lowest_lane(outst_s);
    ack_ok_s      = m_ack_i && (outst_s != LANE_NONE);

    case (state_q)
      IDLE: begin
        if (s_cyc_i && s_stb_i) begin
          we_d      = s_we_i;
          addr_d    = s_addr_i;
          wdata_d   = s_wdata_i;
          sel_d     = s_sel_i;
          en_d      = lane_enables(s_sel_i);
          iss_d     = LANE_NONE;
          ackm_d    = LANE_NONE;
          iss_cnt_d = CNT_ZERO;
          ack_cnt_d = CNT_ZERO;
          err_d     = 1'b0;
          rdata_d   = {WIDE_DW{1'b0}};
          state_d   = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE, DRAIN: begin
        if (!s_cyc_i) begin
          // Wide master gave up: drop the narrow cycle without a response.
          state_d = IDLE;
        end else if (m_err_i) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          if (accept_s) begin
            iss_d     = iss_q | cur_bit_s;
            iss_cnt_d = iss_cnt_q + CNT_ONE;
          end else begin
            iss_cnt_d = iss_cnt_q;
          end
          if (ack_ok_s) begin
            ackm_d    = ackm_q | (LANE_ONE << ack_lane_s);
            ack_cnt_d = ack_cnt_q + CNT_ONE;
            if (!we_q) begin
              rdata_d[int'(ack_lane_s)*SMALL_DW +: SMALL_DW] = m_rdata_i;
            end else begin
              rdata_d = rdata_q;
            end
          end else begin
            ack_cnt_d = ack_cnt_q;
          end
          if (state_q == ISSUE) begin
            if (pend_s == LANE_NONE) begin
              state_d = RESP;
            end else if (last_accept_s) begin
              state_d = DRAIN;
            end else begin
              state_d = ISSUE;
            end
          end else begin
            if (ack_cnt_d == iss_cnt_q) begin
              state_d = RESP;
            end else begin
              state_d = DRAIN;
            end
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      we_q      <= 1'b0;
      addr_q    <= {ADDRESS_WIDTH{1'b0}};
      wdata_q   <= {WIDE_DW{1'b0}};
      sel_q     <= {(WIDE_DW/8){1'b0}};
      en_q      <= LANE_NONE;
      iss_q     <= LANE_NONE;
      ackm_q    <= LANE_NONE;
      iss_cnt_q <= CNT_ZERO;
      ack_cnt_q <= CNT_ZERO;
      err_q     <= 1'b0;
      rdata_q   <= {WIDE_DW{1'b0}};
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      sel_q     <= sel_d;
      en_q      <= en_d;
      iss_q     <= iss_d;
      ackm_q    <= ackm_d;
      iss_cnt_q <= iss_cnt_d;
      ack_cnt_q <= ack_cnt_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
    end
  end

  // Bus outputs decoded from registered state only.
  always_comb begin
    s_stall_o = (state_q != IDLE);
    s_ack_o   = (state_q == RESP) && !err_q;
    s_err_o   = (state_q == RESP) && err_q;
    s_rdata_o = rdata_q;
    m_cyc_o   = (state_q == ISSUE) || (state_q == DRAIN);
    m_stb_o   = stb_s;
    m_we_o    = m_cyc_o && we_q;
    if (stb_s) begin
      m_addr_o  = ADDRESS_WIDTH'({addr_q, cur_lane_s});
      m_wdata_o = wdata_q[int'(cur_lane_s)*SMALL_DW +: SMALL_DW];
      m_sel_o   = sel_q[int'(cur_lane_s)*SB +: SB];
    end else begin
      m_addr_o  = {ADDRESS_WIDTH{1'b0}};
      m_wdata_o = {SMALL_DW{1'b0}};
      m_sel_o   = {SB{1'b0}};
    end
  end

endmodule

// File: tb/tb_wb_dnsz.sv
// Self-checking bench for wb_dnsz: table of wide transactions against a
// scripted narrow slave, plus hand-written stall/error/abort/reset sequences.
module tb_wb_dnsz;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         s_cyc_i, s_stb_i, s_we_i;
  logic [31:0]  s_addr_i;
  logic [127:0] s_wdata_i;
  logic [15:0]  s_sel_i;
  logic         s_stall_o, s_ack_o, s_err_o;
  logic [127:0] s_rdata_o;
  logic         m_cyc_o, m_stb_o, m_we_o;
  logic [31:0]  m_addr_o;
  logic [31:0]  m_wdata_o;
  logic [3:0]   m_sel_o;
  logic         m_stall_i, m_ack_i, m_err_i;
  logic [31:0]  m_rdata_i;

  wb_dnsz dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .s_cyc_i(s_cyc_i), .s_stb_i(s_stb_i), .s_we_i(s_we_i), .s_addr_i(s_addr_i),
    .s_wdata_i(s_wdata_i), .s_sel_i(s_sel_i), .s_stall_o(s_stall_o), .s_ack_o(s_ack_o),
    .s_rdata_o(s_rdata_o), .s_err_o(s_err_o),
    .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o), .m_addr_o(m_addr_o),
    .m_wdata_o(m_wdata_o), .m_sel_o(m_sel_o), .m_stall_i(m_stall_i), .m_ack_i(m_ack_i),
    .m_err_i(m_err_i), .m_rdata_i(m_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- scripted narrow slave ----------------
  typedef struct { int due; logic [31:0] dat; bit err; } rsp_t;
  rsp_t        rq[$];
  int          stall_beat, stall_left, lat, err_beat, beat_n, nlog;
  logic [31:0] log_addr [0:15];
  logic [31:0] log_data [0:15];
  logic [3:0]  log_sel  [0:15];
  logic        log_we   [0:15];
  logic [3:0]  strobed;

  function automatic logic [31:0] rd(input logic [31:0] a);
    return {16'hD00D, a[15:0]};
  endfunction

  task automatic slave_cfg(input int sb, input int sc, input int l, input int eb);
    @(posedge clk_i);
    stall_beat = sb; stall_left = sc; lat = l; err_beat = eb;
    beat_n = 0; nlog = 0; strobed = 4'h0;
    rq.delete();
  endtask

  initial begin
    m_stall_i = 1'b0; m_ack_i = 1'b0; m_err_i = 1'b0; m_rdata_i = 32'h0;
    stall_beat = -1; stall_left = 0; lat = 1; err_beat = -1; beat_n = 0; nlog = 0;
    strobed = 4'h0;
    forever begin
      @(negedge clk_i);
      m_ack_i = 1'b0; m_err_i = 1'b0; m_rdata_i = 32'h0;
      if (rq.size() > 0 && rq[0].due == cyc) begin
        if (rq[0].err) m_err_i = 1'b1;
        else begin m_ack_i = 1'b1; m_rdata_i = rq[0].dat; end
        void'(rq.pop_front());
      end
      if (m_stb_o) begin
        strobed[m_addr_o[1:0]] = 1'b1;
        if (beat_n == stall_beat && stall_left > 0) begin
          m_stall_i = 1'b1;
          stall_left--;
        end else begin
          m_stall_i = 1'b0;
          if (nlog < 16) begin
            log_addr[nlog] = m_addr_o; log_data[nlog] = m_wdata_o;
            log_sel[nlog] = m_sel_o; log_we[nlog] = m_we_o;
            nlog++;
          end
          rq.push_back('{due: cyc + lat, dat: rd(m_addr_o), err: (beat_n == err_beat)});
          beat_n++;
        end
      end else begin
        m_stall_i = 1'b0;
      end
    end
  end

  // ---------------- wide master helpers ----------------
  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [127:0] wd,
                         input logic [15:0] sel, input int abort_at, input int probe_off,
                         output int rlat, output int nack, output int nerr,
                         output logic [127:0] rdat, output logic probe);
    @(negedge clk_i);
    s_cyc_i = 1'b1; s_stb_i = 1'b1; s_we_i = we; s_addr_i = addr;
    s_wdata_i = wd; s_sel_i = sel;
    rlat = -1; nack = 0; nerr = 0; rdat = 128'h0; probe = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk_i);
      s_stb_i = 1'b0;
      if (i == abort_at) s_cyc_i = 1'b0;
      if (i == probe_off) probe = m_cyc_o;
      if (s_ack_o) nack++;
      if (s_err_o) nerr++;
      if ((s_ack_o || s_err_o) && rlat < 0) begin
        rlat = i; rdat = s_rdata_o; s_cyc_i = 1'b0;
      end
    end
  endtask

  task automatic check_beats(input string tag, input logic we, input logic [31:0] nbase,
                             input logic [127:0] wd, input logic [15:0] sel, input logic [3:0] lanes);
    int n, j;
    n = 0;
    for (int k = 0; k < 4; k++) if (lanes[k]) n++;
    chk({tag, "_nbeats"}, 128'(nlog), 128'(n));
    j = 0;
    for (int k = 0; k < 4; k++) begin
      if (lanes[k] && j < nlog) begin
        chk({tag, "_addr"}, 128'(log_addr[j]), 128'(nbase + 32'(k)));
        chk({tag, "_sel"}, 128'(log_sel[j]), 128'(sel[k*4 +: 4]));
        chk({tag, "_we"}, 128'(log_we[j]), 128'(we));
        if (we) chk({tag, "_wdata"}, 128'(log_data[j]), 128'(wd[k*32 +: 32]));
        j++;
      end
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ctrl_zero"},
        128'({s_stall_o, s_ack_o, s_err_o, m_cyc_o, m_stb_o, m_we_o, m_addr_o, m_wdata_o, m_sel_o}),
        128'h0);
    chk({tag, "_rdata_zero"}, s_rdata_o, 128'h0);
  endtask

  typedef struct {
    logic         we;
    logic [31:0]  addr;
    logic [127:0] wdata;
    logic [15:0]  sel;
    logic [31:0]  nbase;
    logic [3:0]   lanes;
    int           lat;
    logic [127:0] rdata;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int rlat, nack, nerr;
    logic [127:0] rdat;
    logic probe;

    vecs[0] = '{1'b1, 32'h10, 128'h4444_4444_3333_3333_2222_2222_1111_1111, 16'hFFFF,
                32'h40, 4'hF, 6, 128'h0};
    vecs[2] = '{1'b0, 32'h7, 128'h0, 16'hFFFF, 32'h1C, 4'hF, 6,
                128'hD00D001F_D00D001E_D00D001D_D00D001C};
    vecs[5] = '{1'b0, 32'hFFFF_FFFF, 128'h0, 16'hFFFF, 32'hFFFF_FFFC, 4'hF, 6,
                128'hD00DFFFF_D00DFFFE_D00DFFFD_D00DFFFC};
`ifdef WB_DNSZ_SKIP_EMPTY_LANES_EN
    vecs[1] = '{1'b0, 32'h3, 128'h0, 16'h00F0, 32'hC, 4'b0010, 3,
                128'h00000000_00000000_D00D000D_00000000};
    vecs[3] = '{1'b1, 32'h100, 128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD, 16'h0F0F,
                32'h400, 4'b0101, 4, 128'h0};
    vecs[4] = '{1'b0, 32'h55, 128'h0, 16'h0000, 32'h154, 4'b0000, 2, 128'h0};
    vecs[6] = '{1'b0, 32'h2, 128'h0, 16'h8001, 32'h8, 4'b1001, 4,
                128'hD00D000B_00000000_00000000_D00D0008};
`else
    vecs[1] = '{1'b0, 32'h3, 128'h0, 16'h00F0, 32'hC, 4'hF, 6,
                128'hD00D000F_D00D000E_D00D000D_D00D000C};
    vecs[3] = '{1'b1, 32'h100, 128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD, 16'h0F0F,
                32'h400, 4'hF, 6, 128'h0};
    vecs[4] = '{1'b0, 32'h55, 128'h0, 16'h0000, 32'h154, 4'hF, 6,
                128'hD00D0157_D00D0156_D00D0155_D00D0154};
    vecs[6] = '{1'b0, 32'h2, 128'h0, 16'h8001, 32'h8, 4'hF, 6,
                128'hD00D000B_D00D000A_D00D0009_D00D0008};
`endif

    rst_i = 1'b1; s_cyc_i = 1'b0; s_stb_i = 1'b0; s_we_i = 1'b0;
    s_addr_i = 32'h0; s_wdata_i = 128'h0; s_sel_i = 16'h0;
    repeat (3) @(negedge clk_i);
    check_zero("reset");
    rst_i = 1'b0;

    // Reset held for three cycles while a beat is stalled in ISSUE.
    slave_cfg(0, 50, 1, -1);
    @(negedge clk_i);
    s_cyc_i = 1'b1; s_stb_i = 1'b1; s_we_i = 1'b1; s_addr_i = 32'h9;
    s_wdata_i = 128'h1; s_sel_i = 16'hFFFF;
    @(negedge clk_i); s_stb_i = 1'b0;
    @(negedge clk_i);
    chk("midissue_stb", 128'(m_stb_o), 128'h1);
    rst_i = 1'b1;
    repeat (3) @(negedge clk_i);
    check_zero("midissue_rst");
    rst_i = 1'b0; s_cyc_i = 1'b0;
    slave_cfg(-1, 0, 1, -1);
    run_txn(1'b0, 32'h9, 128'h0, 16'hFFFF, -1, -1, rlat, nack, nerr, rdat, probe);
    chk("post_rst_lat", 128'(rlat), 128'(6));
    chk("post_rst_rdata", rdat, 128'hD00D0027_D00D0026_D00D0025_D00D0024);

    // Table of single wide transactions against a zero-wait slave.
    for (int v = 0; v < 7; v++) begin
      slave_cfg(-1, 0, 1, -1);
      run_txn(vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].sel, -1, -1,
              rlat, nack, nerr, rdat, probe);
      chk($sformatf("vec%0d_lat", v), 128'(rlat), 128'(vecs[v].lat));
      chk($sformatf("vec%0d_nack", v), 128'(nack), 128'h1);
      chk($sformatf("vec%0d_nerr", v), 128'(nerr), 128'h0);
      chk($sformatf("vec%0d_rdata", v), rdat, vecs[v].rdata);
      check_beats($sformatf("vec%0d", v), vecs[v].we, vecs[v].nbase, vecs[v].wdata,
                  vecs[v].sel, vecs[v].lanes);
    end

    // Beat 1 stalled two cycles, acks three cycles after acceptance.
    slave_cfg(1, 2, 3, -1);
    run_txn(1'b0, 32'h20, 128'h0, 16'hFFFF, -1, -1, rlat, nack, nerr, rdat, probe);
    chk("stall_lat", 128'(rlat), 128'(10));
    chk("stall_nack", 128'(nack), 128'h1);
    chk("stall_nerr", 128'(nerr), 128'h0);
    chk("stall_rdata", rdat, 128'hD00D0083_D00D0082_D00D0081_D00D0080);
    check_beats("stall", 1'b0, 32'h80, 128'h0, 16'hFFFF, 4'hF);

    // Error on the second beat while the third is held off by stall.
    slave_cfg(2, 20, 1, 1);
    run_txn(1'b0, 32'h30, 128'h0, 16'hFFFF, -1, 4, rlat, nack, nerr, rdat, probe);
    chk("err_lat", 128'(rlat), 128'(4));
    chk("err_nerr", 128'(nerr), 128'h1);
    chk("err_nack", 128'(nack), 128'h0);
    chk("err_mcyc_low", 128'(probe), 128'h0);
    chk("err_nbeats", 128'(nlog), 128'(2));
    chk("err_lane3_never_strobed", 128'(strobed[3]), 128'h0);

    // Wide master drops s_cyc_i during DRAIN; late narrow acks must be ignored.
    slave_cfg(-1, 0, 4, -1);
    run_txn(1'b0, 32'h40, 128'h0, 16'hFFFF, 5, 6, rlat, nack, nerr, rdat, probe);
    chk("abort_mcyc_low", 128'(probe), 128'h0);
    chk("abort_nack", 128'(nack), 128'h0);
    chk("abort_nerr", 128'(nerr), 128'h0);
    chk("abort_nbeats", 128'(nlog), 128'(4));
    slave_cfg(-1, 0, 1, -1);
    run_txn(1'b1, 32'h11, 128'h0D0D0D0D_0C0C0C0C_0B0B0B0B_0A0A0A0A, 16'hFFFF, -1, -1,
            rlat, nack, nerr, rdat, probe);
    chk("after_abort_lat", 128'(rlat), 128'(6));
    chk("after_abort_nack", 128'(nack), 128'h1);
    check_beats("after_abort", 1'b1, 32'h44, 128'h0D0D0D0D_0C0C0C0C_0B0B0B0B_0A0A0A0A,
                16'hFFFF, 4'hF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
